// File: rtl/dmem_stream_out.sv
// Readout stage between the processor memory stage and dmem_ram: on a start
// edge it sweeps data memory and streams each word as a saturated pixel.
module dmem_stream_out #(
  parameter int DEPTH  = 129600,
  parameter int ADDR_W = 32,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       cpu_address,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_wd,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              done
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [31:0]      PIX_MAX  = 32'((64'd1 << PIX_W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_sync3;
  logic [PIX_W-1:0]   r_pix_data;
  logic               r_pix_valid;
  logic               r_pix_last;
  logic               r_done;

  logic               w_start_rise;
  logic               w_sweeping;
  logic [PIX_W-1:0]   w_pixel;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset branch must clear every flop it owns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= start;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_start_rise = r_sync2 & ~r_sync3;
  assign w_sweeping   = (r_state == FETCH) || (r_state == SEND);

  // Unsigned saturation: anything above the pixel range clips to full scale.
  assign w_pixel = (mem_rd > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : mem_rd[PIX_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_rise) begin
            r_idx   <= '0;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          r_pix_data  <= w_pixel;
          r_pix_valid <= 1'b1;
          r_pix_last  <= (r_idx == LAST_IDX);
          r_state     <= SEND;
        end
        SEND: begin
          if (r_pix_valid && pix_ready) begin
            r_pix_valid <= 1'b0;
            if (r_pix_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= FETCH;
            end
          end
        end
        DONE: begin
          // Re-arm only once the switch is back low, so a held switch cannot retrigger.
          if (!r_sync2) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of this always_comb gets a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    mem_address = ADDR_W'(cpu_address);
    mem_we      = cpu_we;
    mem_wd      = cpu_wd;
    if (w_sweeping) begin
      mem_address = ADDR_W'(r_idx);
      mem_we      = 1'b0;
      mem_wd      = '0;
    end
  end

  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;
  assign pix_last  = r_pix_last;
  assign busy      = w_sweeping;
  assign done      = r_done;

endmodule
